// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared types and constants for the UART transmit path.
//               Provides the byte width and the drain-FSM state encoding
//               used by uart_tx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BSY  = 2'd1,
    WAIT_DONE = 2'd2
  } tx_drain_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_mem
// Description : Register-array byte storage for uart_tx_fifo.
//               Synchronous write, combinational read.
// Ports       : clk      - system clock
//               wr_en    - write mem[wr_ptr] with wr_data at the edge
//               wr_ptr   - write address
//               wr_data  - byte to store
//               rd_ptr   - read address
//               rd_data  - mem[rd_ptr], combinational
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_ptr,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic [DEPTH_BITS-1:0] rd_ptr,
  output logic [BYTE_W-1:0]     rd_data
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  // Storage carries no reset: contents are only read once written.
  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule : uart_tx_fifo_mem
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO with transmit-drain controller feeding uart_tx.
//               Queues bytes at up to one per clock and launches them one
//               at a time through the tx_trig / tx_bsy handshake.
// Ports       : clk       - system clock
//               rst_n     - synchronous active-low reset
//               wr_en     - push wr_data this cycle
//               wr_data   - byte to queue
//               flush     - discard all queued bytes
//               tx_bsy    - busy flag returned from uart_tx
//               tx_trig   - one-cycle launch pulse to uart_tx
//               send_data - byte to uart_tx, stable until the next launch
//               full      - registered, count == depth
//               empty     - registered, count == 0
//               count     - bytes queued, excluding the byte in flight
//               overflow  - one-cycle pulse when a write is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_BITS = 4,
  parameter int BSY_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic                  flush,
  input  logic                  tx_bsy,
  output logic                  tx_trig,
  output logic [BYTE_W-1:0]     send_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow
);

  localparam int                  GUARD_W    = (BSY_WAIT < 2) ? 1 : $clog2(BSY_WAIT + 1);
  localparam logic [GUARD_W-1:0]  GUARD_INIT = GUARD_W'(BSY_WAIT);
  localparam logic [GUARD_W-1:0]  GUARD_ONE  = GUARD_W'(1);
  localparam logic [DEPTH_BITS:0] CNT_FULL   = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] CNT_ONE    = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_trig_q, tx_trig_d;
  logic [BYTE_W-1:0]     send_data_q, send_data_d;
  tx_drain_state_t       state_q, state_d;
  logic [GUARD_W-1:0]    guard_q, guard_d;

  logic                  wr_accept;
  logic                  pop;
  logic [BYTE_W-1:0]     mem_rd_data;

  // Full is judged on the registered flag, so a pop in the same cycle
  // does not rescue a write into a full FIFO.
  assign wr_accept = wr_en && !full_q && !flush;

  // A launch is held off during a flush so the flushed head byte is not
  // sent while the pointers are being cleared.
  assign pop = (state_q == IDLE) && !empty_q && !tx_bsy && !flush;

  uart_tx_fifo_mem #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_ptr  (wr_ptr_q),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // Pointers, occupancy and flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en && full_q && !flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_accept, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
  end

  // Drain FSM next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    tx_trig_d   = 1'b0;
    send_data_d = send_data_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_trig_d   = 1'b1;
          send_data_d = mem_rd_data;
          guard_d     = GUARD_INIT;
          state_d     = WAIT_BSY;
        end
      end
      WAIT_BSY: begin
        if (tx_bsy) begin
          state_d = WAIT_DONE;
        end else if (guard_q <= GUARD_ONE) begin
          // uart_tx never acknowledged; treat the byte as sent.
          guard_d = '0;
          state_d = IDLE;
        end else begin
          guard_d = guard_q - GUARD_ONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_bsy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      tx_trig_q   <= 1'b0;
      send_data_q <= '0;
      state_q     <= IDLE;
      guard_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      tx_trig_q   <= tx_trig_d;
      send_data_q <= send_data_d;
      state_q     <= state_d;
      guard_q     <= guard_d;
    end
  end

  assign tx_trig   = tx_trig_q;
  assign send_data = send_data_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A behavioural uart_tx
//               busy model answers launches; a monitor logs every launch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH_BITS = 4;
  localparam int BSY_WAIT   = 3;
  localparam int N_BSY      = 9;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_HOLD   = 2'd1;
  localparam logic [1:0] MODE_NEVER  = 2'd2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                flush;
  logic                tx_bsy = 1'b0;
  logic                tx_trig;
  logic [7:0]          send_data;
  logic                full;
  logic                empty;
  logic [DEPTH_BITS:0] count;
  logic                overflow;

  logic [1:0]          bsy_mode = MODE_NORMAL;
  int                  bsy_cnt  = 0;
  int                  cyc      = 0;
  logic                prev_trig = 1'b0;
  int                  consec   = 0;
  int                  log_cyc[$];
  logic [7:0]          log_dat[$];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic                wr_en;
    logic [7:0]          wr_data;
    logic [DEPTH_BITS:0] exp_count;
    logic                exp_empty;
    logic                exp_full;
    logic                exp_ovf;
  } vec_t;

  vec_t vecs[$];

  uart_tx_fifo #(
    .DEPTH_BITS (DEPTH_BITS),
    .BSY_WAIT   (BSY_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .tx_bsy    (tx_bsy),
    .tx_trig   (tx_trig),
    .send_data (send_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy for N_BSY cycles starting one cycle after a trigger.
  always @(posedge clk) begin
    if (bsy_mode == MODE_NORMAL) begin
      if (tx_trig) begin
        bsy_cnt <= N_BSY;
        tx_bsy  <= 1'b1;
      end else if (bsy_cnt > 1) begin
        bsy_cnt <= bsy_cnt - 1;
      end else begin
        bsy_cnt <= 0;
        tx_bsy  <= 1'b0;
      end
    end else if (bsy_mode == MODE_HOLD) begin
      tx_bsy <= 1'b1;
    end else begin
      tx_bsy <= 1'b0;
    end
  end

  // Launch monitor.
  always @(negedge clk) begin
    prev_trig <= tx_trig;
    if (tx_trig) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(send_data);
      if (prev_trig) consec <= consec + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_log(input int target, input int budget, input string name);
    int k = 0;
    while (log_dat.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(log_dat.size()), 32'(target));
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    int   base;
    int   w0;
    vec_t v;

    // Burst table: 18 writes into a stalled FIFO, then one idle cycle.
    for (int i = 0; i < 18; i++) begin
      v.wr_en     = 1'b1;
      v.wr_data   = 8'(i);
      v.exp_count = (i < 16) ? (DEPTH_BITS + 1)'(i + 1) : (DEPTH_BITS + 1)'(16);
      v.exp_empty = 1'b0;
      v.exp_full  = (i >= 15);
      v.exp_ovf   = (i >= 16);
      vecs.push_back(v);
    end
    v.wr_en = 1'b0; v.wr_data = 8'h00; v.exp_count = 5'd16;
    v.exp_empty = 1'b0; v.exp_full = 1'b1; v.exp_ovf = 1'b0;
    vecs.push_back(v);

    // ---------------- Reset held two cycles with wr_en high -------------
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'h55; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_trig",  32'(tx_trig), 32'd0);
      chk("reset_data",  32'(send_data), 32'h00);
      chk("reset_full",  32'(full), 32'd0);
    end
    rst_n = 1'b1; wr_en = 1'b0;
    tick(2);

    // ---------------- Single byte ---------------------------------------
    push_byte(8'hA5);
    w0 = cyc;
    chk("single_count_after_wr", 32'(count), 32'd1);
    chk("single_empty_after_wr", 32'(empty), 32'd0);
    chk("single_trig_early",     32'(tx_trig), 32'd0);
    tick(1);
    chk("single_trig",  32'(tx_trig), 32'd1);
    chk("single_data",  32'(send_data), 32'hA5);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_lat",   32'(cyc - w0), 32'd1);
    tick(1);
    chk("single_trig_drop", 32'(tx_trig), 32'd0);
    chk("single_data_hold", 32'(send_data), 32'hA5);
    tick(15);
    chk("single_one_launch", 32'(log_dat.size()), 32'd1);

    // ---------------- Burst with tx_bsy stuck high, overflow ------------
    bsy_mode = MODE_HOLD;
    tick(1);
    for (int i = 0; i < vecs.size(); i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      tick(1);
      chk($sformatf("burst%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("burst%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("burst%0d_full", i),  32'(full),  32'(vecs[i].exp_full));
      chk($sformatf("burst%0d_ovf", i),   32'(overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("burst%0d_trig", i),  32'(tx_trig), 32'd0);
    end
    wr_en = 1'b0;
    base = log_dat.size();
    bsy_mode = MODE_NORMAL;
    wait_log(base + 16, 400, "burst_drain_timeout");
    for (int k = 0; k < 16; k++) begin
      if (base + k < log_dat.size())
        chk($sformatf("burst_order%0d", k), 32'(log_dat[base + k]), 32'(k));
    end
    tick(15);
    chk("burst_empty_end", 32'(empty), 32'd1);
    chk("burst_no_extra", 32'(log_dat.size()), 32'(base + 16));

    // ---------------- Simultaneous push and pop at count 5 --------------
    bsy_mode = MODE_HOLD;
    tick(1);
    for (int k = 0; k < 5; k++) push_byte(8'hB0 + 8'(k));
    tick(1);
    chk("pp_count5", 32'(count), 32'd5);
    base = log_dat.size();
    bsy_mode = MODE_NORMAL;
    tick(1);                       // model drops tx_bsy at this edge
    push_byte(8'hB5);              // write lands on the launch edge
    chk("pp_trig",  32'(tx_trig), 32'd1);
    chk("pp_data",  32'(send_data), 32'hB0);
    chk("pp_count", 32'(count), 32'd5);
    wait_log(base + 6, 200, "pp_drain_timeout");
    for (int k = 0; k < 6; k++) begin
      if (base + k < log_dat.size())
        chk($sformatf("pp_order%0d", k), 32'(log_dat[base + k]), 32'(8'hB0 + 8'(k)));
    end
    tick(15);
    chk("pp_empty_end", 32'(empty), 32'd1);

    // ---------------- Flush while byte 2 is in flight --------------------
    bsy_mode = MODE_HOLD;
    tick(1);
    for (int k = 0; k < 6; k++) push_byte(8'hC0 + 8'(k));
    base = log_dat.size();
    bsy_mode = MODE_NORMAL;
    wait_log(base + 2, 100, "flush_second_launch_timeout");
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick(1);
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_full",  32'(full), 32'd0);
    chk("flush_no_ovf", 32'(overflow), 32'd0);
    tick(40);
    chk("flush_no_more_trig", 32'(log_dat.size()), 32'(base + 2));
    if (base + 1 < log_dat.size()) begin
      chk("flush_byte1", 32'(log_dat[base]), 32'hC0);
      chk("flush_byte2", 32'(log_dat[base + 1]), 32'hC1);
    end
    push_byte(8'hD7);
    tick(1);
    chk("post_flush_trig", 32'(tx_trig), 32'd1);
    chk("post_flush_data", 32'(send_data), 32'hD7);
    tick(15);

    // ---------------- Busy timeout: tx_bsy never rises ----------------
    bsy_mode = MODE_NEVER;
    tick(1);
    base = log_dat.size();
    wr_en = 1'b1; wr_data = 8'hE0;
    tick(1);
    w0 = cyc;
    wr_data = 8'hE1;
    tick(1);
    wr_en = 1'b0;
    wait_log(base + 2, 30, "timeout_launch_timeout");
    if (base + 1 < log_dat.size()) begin
      chk("to_lat",     32'(log_cyc[base] - w0), 32'd1);
      chk("to_spacing", 32'(log_cyc[base + 1] - log_cyc[base]), 32'(BSY_WAIT + 1));
      chk("to_byte1",   32'(log_dat[base]), 32'hE0);
      chk("to_byte2",   32'(log_dat[base + 1]), 32'hE1);
    end
    tick(10);
    chk("to_empty_end", 32'(empty), 32'd1);

    chk("trig_never_consecutive", 32'(consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire
